// File: rtl/puf_uart_pkg.sv
// puf_uart_pkg: shared FSM encoding, protocol bytes and a saturating
// counter helper for the PUF UART command controller.
package puf_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    CHAL,
    CSUM,
    PUF_REQ,
    PUF_WAIT,
    TX_LOAD,
    TX_WAIT
  } state_t;

  localparam logic [7:0] HDR      = 8'hA5;
  localparam logic [7:0] CMD_CHAL = 8'h01;
  localparam logic [7:0] CMD_PING = 8'h02;
  localparam logic [7:0] RPL_PING = 8'h55;
  localparam logic [7:0] RPL_ERR  = 8'hEE;

  // Error counter increment that sticks at 8'hFF instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// uart_byte_timer: inter-byte watchdog. Counts clock cycles since the last
// clear and pulses 'expired' in the cycle the count reaches TIMEOUT_CLKS-1.
module uart_byte_timer #(
  parameter int TIMEOUT_CLKS = 8680
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, otherwise climb and park at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = !clr && (cnt_q == LAST);

endmodule

// File: rtl/puf_uart_cmd_ctrl.sv
// puf_uart_cmd_ctrl: parses A5-framed host commands from the UART RX byte
// stream, launches one PUF evaluation per challenge frame and streams the
// response back through UART TX, MSB byte first.
// Optional feature: define PUF_UART_CHECKSUM_EN to require an XOR checksum
// byte after the challenge; a mismatch is answered with 8'hEE.
module puf_uart_cmd_ctrl
  import puf_uart_pkg::*;
#(
  parameter int CHAL_BYTES   = 8,
  parameter int RESP_BYTES   = 4,
  parameter int TIMEOUT_CLKS = 8680
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_DV,
  input  logic [7:0]              rx_Byte,
  input  logic                    tx_Done,
  output logic                    tx_DV,
  output logic [7:0]              tx_Byte,
  output logic [8*CHAL_BYTES-1:0] puf_Challenge,
  output logic                    puf_Start,
  input  logic [8*RESP_BYTES-1:0] puf_Response,
  input  logic                    puf_Done,
  output logic                    busy,
  output logic [7:0]              err_Count
);

  localparam int IW = $clog2(CHAL_BYTES + 1);
  localparam int RW = $clog2(RESP_BYTES + 1);
  localparam logic [IW-1:0] CHAL_LAST = IW'(CHAL_BYTES - 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESP_BYTES - 1);

  state_t                  state_q, state_d;
  logic [8*CHAL_BYTES-1:0] chal_q, chal_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [8*RESP_BYTES-1:0] shbuf_q, shbuf_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic                    tx_dv_q, tx_dv_d;
  logic                    puf_start_q, puf_start_d;
  logic                    busy_q, busy_d;
  logic [7:0]              err_q, err_d;
  logic                    err_hit;
  logic                    timer_clr;
  logic                    timer_expired;
`ifdef PUF_UART_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  // The watchdog only runs while a frame is being received; any byte restarts it
  assign timer_clr = rx_DV || !(state_q == CMD || state_q == CHAL || state_q == CSUM);

  uart_byte_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .expired (timer_expired)
  );

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    chal_d    = chal_q;
    idx_d     = idx_q;
    shbuf_d   = shbuf_q;
    rem_d     = rem_q;
    tx_byte_d = tx_byte_q;
`ifdef PUF_UART_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    err_hit   = rx_DV && (state_q inside {PUF_REQ, PUF_WAIT, TX_LOAD, TX_WAIT});

    case (state_q)
      IDLE: begin
        if (rx_DV && rx_Byte == HDR) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (rx_DV) begin
          if (rx_Byte == CMD_CHAL) begin
            state_d = CHAL;
            idx_d   = '0;
`ifdef PUF_UART_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end else if (rx_Byte == CMD_PING) begin
            state_d   = TX_LOAD;
            tx_byte_d = RPL_PING;
            rem_d     = '0;
          end else begin
            state_d   = TX_LOAD;
            tx_byte_d = RPL_ERR;
            rem_d     = '0;
            err_hit   = 1'b1;
          end
        end else if (timer_expired) begin
          state_d = IDLE;
          err_hit = 1'b1;
        end
      end
      CHAL: begin
        if (rx_DV) begin
          chal_d = (chal_q << 8) | (8*CHAL_BYTES)'(rx_Byte);
          idx_d  = idx_q + IW'(1);
`ifdef PUF_UART_CHECKSUM_EN
          csum_d = csum_q ^ rx_Byte;
          if (idx_q == CHAL_LAST) begin
            state_d = CSUM;
          end
`else
          if (idx_q == CHAL_LAST) begin
            state_d = PUF_REQ;
          end
`endif
        end else if (timer_expired) begin
          state_d = IDLE;
          err_hit = 1'b1;
        end
      end
`ifdef PUF_UART_CHECKSUM_EN
      CSUM: begin
        if (rx_DV) begin
          if (rx_Byte == csum_q) begin
            state_d = PUF_REQ;
          end else begin
            state_d   = TX_LOAD;
            tx_byte_d = RPL_ERR;
            rem_d     = '0;
            err_hit   = 1'b1;
          end
        end else if (timer_expired) begin
          state_d = IDLE;
          err_hit = 1'b1;
        end
      end
`endif
      PUF_REQ: begin
        state_d = PUF_WAIT;
      end
      PUF_WAIT: begin
        if (puf_Done) begin
          state_d   = TX_LOAD;
          tx_byte_d = puf_Response[8*RESP_BYTES-1 -: 8];
          shbuf_d   = puf_Response << 8;
          rem_d     = RESP_LAST;
        end
      end
      TX_LOAD: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_Done) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d   = TX_LOAD;
            tx_byte_d = shbuf_q[8*RESP_BYTES-1 -: 8];
            shbuf_d   = shbuf_q << 8;
            rem_d     = rem_q - RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_d       = err_hit ? sat_inc8(err_q) : err_q;
    tx_dv_d     = (state_d == TX_LOAD);
    puf_start_d = (state_d == PUF_REQ);
    busy_d      = (state_d != IDLE);
  end

  // Single state/output register bank; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chal_q      <= '0;
      idx_q       <= '0;
      shbuf_q     <= '0;
      rem_q       <= '0;
      tx_byte_q   <= 8'h00;
      tx_dv_q     <= 1'b0;
      puf_start_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 8'h00;
`ifdef PUF_UART_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      chal_q      <= chal_d;
      idx_q       <= idx_d;
      shbuf_q     <= shbuf_d;
      rem_q       <= rem_d;
      tx_byte_q   <= tx_byte_d;
      tx_dv_q     <= tx_dv_d;
      puf_start_q <= puf_start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef PUF_UART_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx_DV         = tx_dv_q;
  assign tx_Byte       = tx_byte_q;
  assign puf_Challenge = chal_q;
  assign puf_Start     = puf_start_q;
  assign busy          = busy_q;
  assign err_Count     = err_q;

endmodule

// File: tb/tb_puf_uart_cmd_ctrl.sv
// tb_puf_uart_cmd_ctrl: table-driven and randomized frame-level checks of the
// PUF UART command controller against a frame parser model.
module tb_puf_uart_cmd_ctrl;

  localparam int CB = 8;
  localparam int RB = 4;
  localparam int TO = 8680;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_DV;
  logic [7:0]    rx_Byte;
  logic          tx_Done;
  logic          tx_DV;
  logic [7:0]    tx_Byte;
  logic [8*CB-1:0] puf_Challenge;
  logic          puf_Start;
  logic [8*RB-1:0] puf_Response;
  logic          puf_Done;
  logic          busy;
  logic [7:0]    err_Count;

  always #5 clk = ~clk;

  puf_uart_cmd_ctrl #(
    .CHAL_BYTES  (CB),
    .RESP_BYTES  (RB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_DV        (rx_DV),
    .rx_Byte      (rx_Byte),
    .tx_Done      (tx_Done),
    .tx_DV        (tx_DV),
    .tx_Byte      (tx_Byte),
    .puf_Challenge(puf_Challenge),
    .puf_Start    (puf_Start),
    .puf_Response (puf_Response),
    .puf_Done     (puf_Done),
    .busy         (busy),
    .err_Count    (err_Count)
  );

  typedef struct packed {
    int          nbytes;
    logic [95:0] bytes;      // byte i at [95-8*i -: 8]
    bit          is_chal;
    bit          bad_csum;
    logic [31:0] resp;
    int          exp_ntx;
    logic [31:0] exp_tx;     // MSB byte first
    int          exp_starts;
    int          exp_err;    // increment of err_Count
    logic [63:0] exp_chal;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int err_model = 0;

  // Environment state shared with the responder process
  int          cyc = 0;
  int          tx_cd = -1;
  int          puf_cd = -1;
  int          starts = 0;
  logic [63:0] chal_seen = '0;
  logic [31:0] cur_resp;
  int          done_limit;
  bit          stale_req;
  logic [7:0]  txq[$];
  int          dv_cyc[$];
  int          done_cyc[$];

  // UART TX and PUF core responders: observe DUT strobes on the falling edge
  // and answer with randomly delayed completion strobes.
  always @(negedge clk) begin
    cyc          <= cyc + 1;
    tx_Done      <= 1'b0;
    puf_Done     <= 1'b0;
    puf_Response <= 32'($urandom);
    if (!rst_n) begin
      tx_cd  <= -1;
      puf_cd <= -1;
    end else begin
      if (tx_cd == 0) begin
        tx_Done <= 1'b1;
        done_cyc.push_back(cyc);
        tx_cd <= -1;
      end else if (tx_cd > 0) begin
        tx_cd <= tx_cd - 1;
      end
      if (puf_cd == 0) begin
        puf_Done     <= 1'b1;
        puf_Response <= cur_resp;
        puf_cd       <= -1;
      end else if (puf_cd > 0) begin
        puf_cd <= puf_cd - 1;
      end
      if (tx_DV) begin
        txq.push_back(tx_Byte);
        dv_cyc.push_back(cyc);
        if (done_limit < 0 || done_cyc.size() < done_limit) begin
          tx_cd <= int'($urandom_range(0, 3));
        end
      end
      if (puf_Start) begin
        starts    <= starts + 1;
        chal_seen <= puf_Challenge;
        puf_cd    <= int'($urandom_range(0, 4));
      end
      if (stale_req) begin
        tx_Done  <= 1'b1;
        puf_Done <= 1'b1;
      end
    end
  end

  function automatic logic [7:0] byteAt(vec_t v, int i);
    return v.bytes[95-8*i -: 8];
  endfunction

  // Frame-level reference: skip non-header bytes, then interpret the command
  function automatic vec_t predict(vec_t v);
    vec_t        r;
    int          i;
    logic [7:0]  c;
    logic [7:0]  x;
    logic [63:0] ch;
    r = v;
    r.exp_ntx = 0; r.exp_tx = '0; r.exp_starts = 0; r.exp_err = 0; r.exp_chal = '0;
    i = 0;
    while (i < v.nbytes && byteAt(v, i) != 8'hA5) i++;
    if (i + 1 < v.nbytes) begin
      c = byteAt(v, i + 1);
      if (c == 8'h02) begin
        r.exp_ntx = 1; r.exp_tx = {8'h55, 24'h0};
      end else if (c == 8'h01) begin
        x = 8'h00; ch = '0;
        for (int k = 0; k < CB; k++) begin
          ch = {ch[55:0], byteAt(v, i + 2 + k)};
          x  = x ^ byteAt(v, i + 2 + k);
        end
        r.exp_starts = 1; r.exp_chal = ch; r.exp_ntx = RB; r.exp_tx = v.resp;
`ifdef PUF_UART_CHECKSUM_EN
        if (v.bad_csum) begin
          r.exp_starts = 0; r.exp_chal = '0; r.exp_ntx = 1;
          r.exp_tx = {8'hEE, 24'h0}; r.exp_err = 1;
        end
`endif
      end else begin
        r.exp_ntx = 1; r.exp_tx = {8'hEE, 24'h0}; r.exp_err = 1;
      end
    end
    return r;
  endfunction

  function automatic vec_t randomVec();
    vec_t       v;
    int         kind;
    int         nstray;
    logic [7:0] b;
    v = '0;
    kind   = int'($urandom_range(0, 3));
    nstray = (kind == 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 1));
    for (int k = 0; k < nstray; k++) begin
      do b = 8'($urandom); while (b == 8'hA5);
      v.bytes[95-8*v.nbytes -: 8] = b;
      v.nbytes++;
    end
    if (kind != 3) begin
      v.bytes[95-8*v.nbytes -: 8] = 8'hA5;
      v.nbytes++;
      if (kind == 0) b = 8'h01;
      else if (kind == 1) b = 8'h02;
      else begin
        do b = 8'($urandom); while (b == 8'h01 || b == 8'h02);
      end
      v.bytes[95-8*v.nbytes -: 8] = b;
      v.nbytes++;
      if (kind == 0) begin
        v.is_chal = 1'b1;
        for (int k = 0; k < CB; k++) begin
          v.bytes[95-8*v.nbytes -: 8] = 8'($urandom);
          v.nbytes++;
        end
`ifdef PUF_UART_CHECKSUM_EN
        v.bad_csum = ($urandom_range(0, 3) == 0);
`endif
      end
    end
    v.resp = $urandom;
    return predict(v);
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxgap);
    rx_Byte = b;
    rx_DV   = 1'b1;
    @(negedge clk);
    rx_DV   = 1'b0;
    rx_Byte = 8'($urandom);
    repeat (int'($urandom_range(0, maxgap))) @(negedge clk);
  endtask

  task automatic sendFrame(input vec_t v);
    logic [7:0] x;
    x = 8'h00;
    cur_resp = v.resp;
    for (int i = 0; i < v.nbytes; i++) begin
      sendByte(byteAt(v, i), 2);
      if (v.is_chal && i >= v.nbytes - CB) x = x ^ byteAt(v, i);
    end
`ifdef PUF_UART_CHECKSUM_EN
    if (v.is_chal) sendByte(v.bad_csum ? (x ^ 8'h5A) : x, 2);
`endif
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkValue({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  int base_starts;

  task automatic applyStimulus(input vec_t v, input string name);
    txq.delete(); dv_cyc.delete(); done_cyc.delete();
    base_starts = starts;
    sendFrame(v);
    repeat (3) @(negedge clk);
    waitIdle(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    err_model = (err_model + v.exp_err > 255) ? 255 : err_model + v.exp_err;
    checkValue({name, "_ntx"}, 64'(txq.size()), 64'(v.exp_ntx));
    for (int k = 0; k < v.exp_ntx && k < txq.size(); k++)
      checkValue($sformatf("%s_tx%0d", name, k), 64'(txq[k]), 64'(v.exp_tx[31-8*k -: 8]));
    for (int k = 1; k < dv_cyc.size() && k <= done_cyc.size(); k++)
      checkValue($sformatf("%s_lat%0d", name, k), 64'(dv_cyc[k] - done_cyc[k-1]), 64'd1);
    checkValue({name, "_starts"}, 64'(starts - base_starts), 64'(v.exp_starts));
    if (v.exp_starts != 0) checkValue({name, "_chal"}, chal_seen, v.exp_chal);
    checkValue({name, "_err"}, 64'(err_Count), 64'(err_model));
  endtask

  task automatic checkResetValues(input string name);
    checkValue({name, "_txdv"},  64'(tx_DV), 64'd0);
    checkValue({name, "_txbyte"}, 64'(tx_Byte), 64'd0);
    checkValue({name, "_start"}, 64'(puf_Start), 64'd0);
    checkValue({name, "_chal"},  puf_Challenge, 64'd0);
    checkValue({name, "_busy"},  64'(busy), 64'd0);
    checkValue({name, "_err"},   64'(err_Count), 64'd0);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   n0;

  initial begin
    rst_n = 1'b1; rx_DV = 1'b0; rx_Byte = 8'h00;
    done_limit = -1; stale_req = 1'b0; cur_resp = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table: {bytes, response} -> {tx bytes, starts, err increment, challenge}
    v = '0; v.nbytes = 10; v.bytes = {8'hA5, 8'h01, 64'h0001020304050607, 16'h0}; v.is_chal = 1;
    v.resp = 32'hDEADBEEF; v.exp_ntx = 4; v.exp_tx = 32'hDEADBEEF; v.exp_starts = 1;
    v.exp_chal = 64'h0001020304050607; vecs.push_back(v);
    v = '0; v.nbytes = 2; v.bytes = {8'hA5, 8'h02, 80'h0}; v.exp_ntx = 1; v.exp_tx = 32'h55000000;
    vecs.push_back(v);
    v = '0; v.nbytes = 2; v.bytes = {8'hA5, 8'h7C, 80'h0}; v.exp_ntx = 1; v.exp_tx = 32'hEE000000;
    v.exp_err = 1; vecs.push_back(v);
    v = '0; v.nbytes = 2; v.bytes = {8'h11, 8'h22, 80'h0}; vecs.push_back(v);
    v = '0; v.nbytes = 2; v.bytes = {8'hA5, 8'hA5, 80'h0}; v.exp_ntx = 1; v.exp_tx = 32'hEE000000;
    v.exp_err = 1; vecs.push_back(v);
    v = '0; v.nbytes = 10; v.bytes = {8'hA5, 8'h01, 64'hF0E1D2C3B4A59687, 16'h0}; v.is_chal = 1;
    v.resp = 32'h12345678; v.exp_ntx = 4; v.exp_tx = 32'h12345678; v.exp_starts = 1;
    v.exp_chal = 64'hF0E1D2C3B4A59687; vecs.push_back(v);
`ifdef PUF_UART_CHECKSUM_EN
    v = '0; v.nbytes = 10; v.bytes = {8'hA5, 8'h01, 64'h0001020304050607, 16'h0}; v.is_chal = 1;
    v.bad_csum = 1; v.resp = 32'hCAFEF00D; v.exp_ntx = 1; v.exp_tx = 32'hEE000000; v.exp_err = 1;
    vecs.push_back(v);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Inter-byte timeout in the middle of a challenge
    txq.delete(); base_starts = starts;
    sendByte(8'hA5, 0); sendByte(8'h01, 0);
    sendByte(8'h10, 0); sendByte(8'h20, 0); sendByte(8'h30, 0);
    repeat (TO - 10) @(negedge clk);
    checkValue("to_busy_before", 64'(busy), 64'd1);
    n0 = 0;
    while (busy && n0 < 40) begin
      @(negedge clk);
      n0++;
    end
    checkValue("to_busy_after", 64'(busy), 64'd0);
    err_model = err_model + 1;
    checkValue("to_err", 64'(err_Count), 64'(err_model));
    checkValue("to_ntx", 64'(txq.size()), 64'd0);
    checkValue("to_starts", 64'(starts - base_starts), 64'd0);
    applyStimulus(vecs[0], "after_to");
    checkOutput(vecs[0], "after_to");

    // Reset while waiting for tx_Done of byte 2 of 4
    txq.delete(); dv_cyc.delete(); done_cyc.delete();
    done_limit = 1;
    sendFrame(vecs[0]);
    n0 = 0;
    while (txq.size() < 2 && n0 < 300) begin
      @(negedge clk);
      n0++;
    end
    checkValue("mid_txq", 64'(txq.size()), 64'd2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetValues("midrst");
    rst_n = 1'b1;
    done_limit = -1;
    err_model = 0;
    @(negedge clk);
    stale_req = 1'b1;
    repeat (2) @(negedge clk);
    stale_req = 1'b0;
    repeat (5) @(negedge clk);
    checkValue("stale_txq", 64'(txq.size()), 64'd2);
    checkValue("stale_busy", 64'(busy), 64'd0);
    applyStimulus(vecs[0], "after_rst");
    checkOutput(vecs[0], "after_rst");

    // Randomized frames against the frame-level model
    for (int i = 0; i < 25; i++) begin
      v = randomVec();
      applyStimulus(v, $sformatf("rnd%0d", i));
      checkOutput(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
